// File: rtl/mem_stage_if.sv
// EX/MEM -> MEM/WB bundle for the MEM stage.
// The master side drives the EX/MEM slot and the pipeline controls.
// The slave side (the MEM stage) returns the registered write-back triple
// and the misalignment report.
interface mem_stage_if;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;
  logic [31:0] misalign_addr;

  modport master (
    output stall, flush, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_funct3, ex_alu_result, ex_wdata, ex_rd,
    input  wb_valid, wb_reg_write, wb_rd, wb_data, misalign, misalign_addr
  );

  modport slave (
    input  stall, flush, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
           ex_funct3, ex_alu_result, ex_wdata, ex_rd,
    output wb_valid, wb_reg_write, wb_rd, wb_data, misalign, misalign_addr
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: word-addressed data RAM with byte-lane
// stores, sign/zero-extending loads, misalignment detection, and the
// registered MEM/WB write-back triple.
module mem_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);

  logic [31:0] ram_q [DEPTH];

  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;
  logic [31:0] misalign_addr_q, misalign_addr_d;

  logic [AW-1:0] idx_s;
  logic [1:0]    off_s;
  logic          act_s;
  logic          mis_s;
  logic          we_s;
  logic [3:0]    be_s;
  logic [31:0]   wdat_s;
  logic [31:0]   rdata_s;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic r;
    case (f3[1:0])
      2'b01:   r = off[0];
      2'b10:   r = (off != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte lanes touched by a store of the given size at the given offset.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Replicate store data so every enabled lane sees the right bits.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Lane-select and extend a loaded word; unused encodings act as LW.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    shifted = word >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign idx_s   = bus.ex_alu_result[AW+1:2];
  assign off_s   = bus.ex_alu_result[1:0];
  assign act_s   = bus.ex_valid & ~bus.flush & ~bus.stall;
  assign mis_s   = (bus.ex_mem_read | bus.ex_mem_write) & is_misaligned(bus.ex_funct3, off_s);
  // A store presented while reset is held must not reach the RAM.
  assign we_s    = act_s & bus.ex_mem_write & ~mis_s & ~reset;
  assign be_s    = byte_en(bus.ex_funct3, off_s);
  assign wdat_s  = store_data(bus.ex_funct3, bus.ex_wdata);
  assign rdata_s = ram_q[idx_s];

  // Byte-lane masked RAM write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_s && be_s[i]) begin
        ram_q[idx_s][8*i +: 8] <= wdat_s[8*i +: 8];
      end
    end
  end

  // Next MEM/WB contents: hold on stall, bubble when idle, else the result.
  always_comb begin
    wb_valid_d      = wb_valid_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_rd_d         = wb_rd_q;
    wb_data_d       = wb_data_q;
    misalign_d      = misalign_q;
    misalign_addr_d = misalign_addr_q;
    if (!bus.stall) begin
      if (act_s) begin
        wb_valid_d     = 1'b1;
        wb_rd_d        = bus.ex_rd;
        wb_reg_write_d = bus.ex_reg_write & ~bus.ex_mem_write & ~mis_s;
        misalign_d     = mis_s;
        if (mis_s) begin
          misalign_addr_d = bus.ex_alu_result;
        end else begin
          misalign_addr_d = misalign_addr_q;
        end
        if (bus.ex_mem_read && !mis_s) begin
          wb_data_d = load_extend(bus.ex_funct3, rdata_s, off_s);
        end else begin
          wb_data_d = bus.ex_alu_result;
        end
      end else begin
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
        wb_rd_d        = 5'd0;
        misalign_d     = 1'b0;
      end
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  // MEM/WB pipeline register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_data_q       <= 32'h0000_0000;
      misalign_q      <= 1'b0;
      misalign_addr_q <= 32'h0000_0000;
    end else begin
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_rd_q         <= wb_rd_d;
      wb_data_q       <= wb_data_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_reg_write  = wb_reg_write_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.misalign      = misalign_q;
  assign bus.misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes hand-computed expected
// MEM/WB contents for every unstalled edge, the monitor pops and compares
// after each edge and checks that stalled edges hold the outputs.
module tb_mem_stage;

  logic clk;
  logic reset;
  mem_stage_if bus ();

  mem_stage #(.DEPTH(256), .AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       nm;
    logic        v;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        chk;
    logic        mis;
    logic [31:0] ma;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare after every edge that was neither reset nor stalled.
  initial begin
    logic rs, st;
    exp_t e;
    logic        s_v, s_rw, s_mis;
    logic [4:0]  s_rd;
    logic [31:0] s_d, s_ma;
    s_v = 1'b0; s_rw = 1'b0; s_mis = 1'b0; s_rd = 5'd0; s_d = 32'h0; s_ma = 32'h0;
    forever begin
      @(posedge clk);
      rs = reset;
      st = bus.stall;
      @(negedge clk);
      if (!rs) begin
        if (st) begin
          tests++;
          if (bus.wb_valid !== s_v || bus.wb_reg_write !== s_rw || bus.wb_rd !== s_rd ||
              bus.wb_data !== s_d || bus.misalign !== s_mis || bus.misalign_addr !== s_ma) begin
            fails++;
            $display("FAIL stall_hold: got v=%0b rw=%0b rd=%0d d=%h mis=%0b ma=%h, required v=%0b rw=%0b rd=%0d d=%h mis=%0b ma=%h",
                     bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.misalign, bus.misalign_addr,
                     s_v, s_rw, s_rd, s_d, s_mis, s_ma);
          end
        end else if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty: got output with no expectation queued, required a queued entry");
        end else begin
          e = q.pop_front();
          tests++;
          if (bus.wb_valid !== e.v || bus.wb_reg_write !== e.rw || bus.wb_rd !== e.rd ||
              (e.chk && bus.wb_data !== e.d) || bus.misalign !== e.mis || bus.misalign_addr !== e.ma) begin
            fails++;
            $display("FAIL %s: got v=%0b rw=%0b rd=%0d d=%h mis=%0b ma=%h, required v=%0b rw=%0b rd=%0d d=%h(chk=%0b) mis=%0b ma=%h",
                     e.nm, bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.misalign,
                     bus.misalign_addr, e.v, e.rw, e.rd, e.d, e.chk, e.mis, e.ma);
          end
        end
      end
      s_v = bus.wb_valid; s_rw = bus.wb_reg_write; s_rd = bus.wb_rd;
      s_d = bus.wb_data; s_mis = bus.misalign; s_ma = bus.misalign_addr;
    end
  end

  task automatic set_in(input logic v, input logic mr, input logic mw, input logic rw,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] rd, input logic st, input logic fl);
    bus.ex_valid = v; bus.ex_mem_read = mr; bus.ex_mem_write = mw; bus.ex_reg_write = rw;
    bus.ex_funct3 = f3; bus.ex_alu_result = a; bus.ex_wdata = wd; bus.ex_rd = rd;
    bus.stall = st; bus.flush = fl;
  endtask

  // One cycle of stimulus; unstalled cycles queue their expected result.
  task automatic cyc(input string nm, input logic v, input logic mr, input logic mw, input logic rw,
                     input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [4:0] rd, input logic st, input logic fl,
                     input logic ev, input logic erw, input logic [4:0] erd, input logic [31:0] ed,
                     input logic ec, input logic em, input logic [31:0] ema);
    exp_t e;
    set_in(v, mr, mw, rw, f3, a, wd, rd, st, fl);
    if (!st) begin
      e.nm = nm; e.v = ev; e.rw = erw; e.rd = erd; e.d = ed; e.chk = ec; e.mis = em; e.ma = ema;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic t_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [4:0] rd, input logic [31:0] ed, input logic [31:0] ema);
    cyc(nm, 1'b1, 1'b1, 1'b0, 1'b1, f3, a, 32'h0, rd, 1'b0, 1'b0,
        1'b1, 1'b1, rd, ed, 1'b1, 1'b0, ema);
  endtask

  task automatic t_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] ema);
    cyc(nm, 1'b1, 1'b0, 1'b1, 1'b1, f3, a, wd, 5'd7, 1'b0, 1'b0,
        1'b1, 1'b0, 5'd7, 32'h0, 1'b0, 1'b0, ema);
  endtask

  task automatic t_idle(input string nm, input logic [31:0] ema);
    cyc(nm, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0,
        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, ema);
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tests++;
    if (bus.wb_valid !== 1'b0 || bus.wb_reg_write !== 1'b0 || bus.wb_rd !== 5'd0 ||
        bus.wb_data !== 32'h0 || bus.misalign !== 1'b0 || bus.misalign_addr !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b rw=%0b rd=%0d d=%h mis=%0b ma=%h, required all zero",
               bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.misalign, bus.misalign_addr);
    end

    // Word store and load-after-store, then all load flavours.
    t_store("sw_40",   3'b010, 32'h40, 32'h1234_57FF, 32'h0);
    t_load ("lw_40",   3'b010, 32'h40, 5'd18, 32'h1234_57FF, 32'h0);
    t_load ("lb_40",   3'b000, 32'h40, 5'd1,  32'hFFFF_FFFF, 32'h0);
    t_load ("lh_40",   3'b001, 32'h40, 5'd2,  32'h0000_57FF, 32'h0);
    t_load ("lhu_42",  3'b101, 32'h42, 5'd3,  32'h0000_1234, 32'h0);
    t_load ("lbu_43",  3'b100, 32'h43, 5'd4,  32'h0000_0012, 32'h0);
    // Sub-word stores leave the other lanes alone.
    t_store("sb_41",   3'b000, 32'h41, 32'hFFFF_FFAB, 32'h0);
    t_load ("lw_sb",   3'b010, 32'h40, 5'd11, 32'h1234_ABFF, 32'h0);
    t_load ("lbu_41",  3'b100, 32'h41, 5'd12, 32'h0000_00AB, 32'h0);
    t_store("sh_42",   3'b001, 32'h42, 32'h1111_BEEF, 32'h0);
    t_load ("lw_sh",   3'b010, 32'h40, 5'd13, 32'hBEEF_ABFF, 32'h0);
    t_load ("lh_neg",  3'b001, 32'h42, 5'd14, 32'hFFFF_BEEF, 32'h0);
    t_load ("lw_wrap", 3'b010, 32'h440, 5'd15, 32'hBEEF_ABFF, 32'h0);
    // Misaligned accesses.
    cyc("lw_mis42", 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h42, 32'h0, 5'd9, 1'b0, 1'b0,
        1'b1, 1'b0, 5'd9, 32'h0, 1'b0, 1'b1, 32'h42);
    t_idle("mis_pulse_end", 32'h42);
    cyc("sw_mis41", 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h41, 32'h0, 5'd7, 1'b0, 1'b0,
        1'b1, 1'b0, 5'd7, 32'h0, 1'b0, 1'b1, 32'h41);
    t_load("lw_after_mis", 3'b010, 32'h40, 5'd16, 32'hBEEF_ABFF, 32'h41);
    cyc("lh_mis43", 1'b1, 1'b1, 1'b0, 1'b1, 3'b001, 32'h43, 32'h0, 5'd10, 1'b0, 1'b0,
        1'b1, 1'b0, 5'd10, 32'h0, 1'b0, 1'b1, 32'h43);
    // ALU op stalled three cycles (misalign pulse stretched), then released.
    repeat (3) cyc("alu_stall", 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h2, 32'h0, 5'd5, 1'b1, 1'b0,
                   1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc("alu_rd5", 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h2, 32'h0, 5'd5, 1'b0, 1'b0,
        1'b1, 1'b1, 5'd5, 32'h2, 1'b1, 1'b0, 32'h43);
    // Flush under stall is ignored; plain flush registers a bubble.
    cyc("flush_stall", 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd99, 32'h0, 5'd6, 1'b1, 1'b1,
        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    cyc("alu_flush", 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h2, 32'h0, 5'd5, 1'b0, 1'b1,
        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h43);
    cyc("alu_rd0", 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h77, 32'h0, 5'd0, 1'b0, 1'b0,
        1'b1, 1'b1, 5'd0, 32'h77, 1'b1, 1'b0, 32'h43);
    // A stalled store must not write the RAM.
    cyc("sw_stalled", 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 5'd7, 1'b1, 1'b0,
        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
    t_idle("idle_after_stall", 32'h43);
    t_load("lw_no_stall_wr", 3'b010, 32'h40, 5'd17, 32'hBEEF_ABFF, 32'h43);

    // Asynchronous reset with a store pending.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 5'd7, 1'b0, 1'b0);
    #5;
    reset = 1'b1;
    #1;
    tests++;
    if (bus.wb_valid !== 1'b0 || bus.wb_reg_write !== 1'b0 || bus.wb_rd !== 5'd0 ||
        bus.wb_data !== 32'h0 || bus.misalign !== 1'b0 || bus.misalign_addr !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: got v=%0b rw=%0b rd=%0d d=%h mis=%0b ma=%h, required all zero",
               bus.wb_valid, bus.wb_reg_write, bus.wb_rd, bus.wb_data, bus.misalign, bus.misalign_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    t_load("lw_after_reset", 3'b010, 32'h40, 5'd19, 32'hBEEF_ABFF, 32'h0);
    t_idle("drain0", 32'h0);
    t_idle("drain1", 32'h0);

    budget = 0;
    while (q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
